execution_sequencer: RTL and testbench
======================================

EXECUTION_SEQUENCER -- requirements
Module: execution_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, width of program counter and instruction-memory address.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 15, max wait cycles for imem_ack before fault (legal 1..255).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_WIDTH  fetch address (equals pc).
REQ-007 SHALL have port imem_ack  input  1  fetch complete; imem_data valid same cycle.
REQ-008 SHALL have port imem_data  input  32  fetched instruction word.
REQ-009 SHALL have port instruction_data  output  32  held instruction register, feeds instruction decoder.
REQ-010 SHALL have port opcode  input  4  decoded opcode from instruction decoder.
REQ-011 SHALL have port input_immediate_1  input  8  decoded immediate 1 (jump target).
REQ-012 SHALL have port output_enable  output  1  data-path register write enable.
REQ-013 SHALL have port output_source_selector  output  1  0 = ALU result, 1 = immediate.
REQ-014 SHALL have port alu_opcode  output  2  ALU operation select.
REQ-015 SHALL have port pc  output  PC_WIDTH  current program counter.
REQ-016 SHALL have port retired  output  16  retired-instruction counter.
REQ-017 SHALL have port halted  output  1  HALT executed, sticky.
REQ-018 SHALL have port fault  output  1  illegal opcode or fetch timeout, sticky.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXECUTE, HALT, FAULT.
REQ-020 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 SHALL load instruction_data<=imem_data, clear wait counter, go DECODE.
REQ-021 FETCH without ack: wait counter SHALL increment; when counter reaches FETCH_TIMEOUT with no ack that cycle, go FAULT; ack on the final allowed cycle SHALL win over timeout.
REQ-022 imem_req SHALL be 0 in all states except FETCH; imem_ack outside FETCH SHALL be ignored.
REQ-023 DECODE: one cycle, no outputs asserted, allows combinational decoder to settle; SHALL register opcode and input_immediate_1, go EXECUTE.
REQ-024 EXECUTE decoding of registered opcode: 0x0 NOP; 0x1-0x4 ALU op with alu_opcode=opcode-1, output_enable=1, output_source_selector=0; 0x5 MOV-immediate with output_enable=1, output_source_selector=1; 0x6 JMP; 0xF HALT; 0x7-0xE illegal.
REQ-025 output_enable SHALL be high exactly one cycle (EXECUTE) per ALU/MOV instruction, low otherwise; alu_opcode SHALL be 0 outside EXECUTE.
REQ-026 After NOP/ALU/MOV: pc<=pc+1 modulo 2^PC_WIDTH, go FETCH.
REQ-027 After JMP: pc<=input_immediate_1 zero-extended/truncated to PC_WIDTH, go FETCH.
REQ-028 HALT opcode: go HALT, pc unchanged, halted<=1; illegal opcode: go FAULT, pc unchanged, fault<=1.
REQ-029 retired SHALL increment by 1 in each EXECUTE of NOP/ALU/MOV/JMP/HALT, not for illegal; wraps 0xFFFF->0x0000.
REQ-030 HALT and FAULT SHALL be terminal until reset; no requests, no writes.
REQ-031 Zero-wait memory (ack in first FETCH cycle) SHALL give 3 cycles per instruction.

Reset
REQ-032 reset=1 at rising edge SHALL set state FETCH, pc=0, instruction_data=0, retired=0, wait counter=0, halted=0, fault=0, output_enable=0, output_source_selector=0, alu_opcode=0; imem_req=1 first cycle after reset release.
REQ-033 reset SHALL override any state, including mid-fetch with ack asserted and EXECUTE (no write, no pc update that cycle).

Verification
REQ-034 Reset then zero-wait memory returning opcodes 0x1,0x5,0x0 -> output_enable pulses at cycles 3 and 6, alu_opcode=0 then source_sel=1, pc=3, retired=3 after cycle 9.
REQ-035 ack delayed 4 cycles, FETCH_TIMEOUT=15 -> imem_req held 5 cycles, no fault; ack never asserted -> fault=1 after 15 wait cycles, imem_req drops.
REQ-036 JMP with immediate 0x40 at pc=0x10 -> next imem_addr=0x40; pc=0xFF NOP -> next imem_addr=0x00.
REQ-037 Opcode 0x9 -> fault=1, output_enable never asserted, retired unchanged; opcode 0xF -> halted=1, retired+1, no further imem_req.
REQ-038 reset asserted in EXECUTE of ALU op and during HALT -> output_enable=0 that cycle, all outputs per REQ-032, fetch restarts at address 0.

Source files
------------

// File: rtl/execution_sequencer.sv
// rtl/execution_sequencer.sv - fetch/decode/execute sequencer with fetch timeout, halt and fault states
module execution_sequencer #(
  parameter int PC_WIDTH      = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instruction_data,
  input  logic [3:0]          opcode,
  input  logic [7:0]          input_immediate_1,
  output logic                output_enable,
  output logic                output_source_selector,
  output logic [1:0]          alu_opcode,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         retired,
  output logic                halted,
  output logic                fault
);

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_HALT    = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [7:0]          wait_q, wait_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [15:0]         retired_q, retired_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic is_nop, is_alu, is_mov, is_jmp, is_halt, is_illegal;
  logic in_exec;

  always_comb begin
    is_nop     = (opcode_q == 4'h0);
    is_alu     = (opcode_q >= 4'h1) && (opcode_q <= 4'h4);
    is_mov     = (opcode_q == 4'h5);
    is_jmp     = (opcode_q == 4'h6);
    is_halt    = (opcode_q == 4'hF);
    is_illegal = !(is_nop || is_alu || is_mov || is_jmp || is_halt);
  end

  // Write-side outputs are masked by reset so a reset landing in EXECUTE never produces a write.
  assign in_exec                = (state_q == ST_EXECUTE) && !reset;
  assign output_enable          = in_exec && (is_alu || is_mov);
  assign output_source_selector = in_exec && is_mov;
  assign alu_opcode             = (in_exec && is_alu) ? 2'(opcode_q - 4'h1) : 2'b00;

  assign imem_req         = (state_q == ST_FETCH);
  assign imem_addr        = pc_q;
  assign instruction_data = instr_q;
  assign pc               = pc_q;
  assign retired          = retired_q;
  assign halted           = halted_q;
  assign fault            = fault_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    wait_d    = wait_q;
    opcode_d  = opcode_q;
    target_d  = target_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    case (state_q)
      ST_FETCH: begin
        // An ack on the last allowed wait cycle is checked first, so it beats the timeout.
        if (imem_ack) begin
          instr_d = imem_data;
          wait_d  = 8'd0;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DECODE: begin
        opcode_d = opcode;
        target_d = PC_WIDTH'(input_immediate_1);
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_illegal) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          retired_d = retired_q + 16'd1;
          if (is_halt) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else if (is_jmp) begin
            pc_d    = target_q;
            state_d = ST_FETCH;
          end else begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      instr_q   <= 32'd0;
      wait_q    <= 8'd0;
      opcode_q  <= 4'd0;
      target_q  <= '0;
      retired_q <= 16'd0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      opcode_q  <= opcode_d;
      target_q  <= target_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_execution_sequencer.sv
// tb/tb_execution_sequencer.sv - directed self-checking bench for execution_sequencer
module tb_execution_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruction_data;
  logic [3:0]  opcode;
  logic [7:0]  input_immediate_1;
  logic        output_enable;
  logic        output_source_selector;
  logic [1:0]  alu_opcode;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        halted;
  logic        fault;

  execution_sequencer #(.PC_WIDTH(8), .FETCH_TIMEOUT(15)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .imem_req               (imem_req),
    .imem_addr              (imem_addr),
    .imem_ack               (imem_ack),
    .imem_data              (imem_data),
    .instruction_data       (instruction_data),
    .opcode                 (opcode),
    .input_immediate_1      (input_immediate_1),
    .output_enable          (output_enable),
    .output_source_selector (output_source_selector),
    .alu_opcode             (alu_opcode),
    .pc                     (pc),
    .retired                (retired),
    .halted                 (halted),
    .fault                  (fault)
  );

  always #5 clock = ~clock;

  // Instruction memory with programmable ack latency; decoder takes opcode from [31:28], immediate from [7:0].
  logic [31:0] mem [0:255];
  int          ack_delay = 0;
  logic        ack_en    = 1'b1;
  int          wcnt      = 0;

  assign imem_data         = mem[imem_addr];
  assign imem_ack          = imem_req && ack_en && (wcnt >= ack_delay);
  assign opcode            = instruction_data[31:28];
  assign input_immediate_1 = instruction_data[7:0];

  always @(posedge clock) begin
    if (reset || !imem_req || imem_ack) wcnt <= 0;
    else                                wcnt <= wcnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 32'hF000_0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  int cnt;

  initial begin
    fill_halt();
    mem[0] = 32'h1000_0000;
    mem[1] = 32'h5000_00AB;
    mem[2] = 32'h0000_0000;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    check("rst_instr", instruction_data, 0);
    check("rst_oe", output_enable, 0);
    check("rst_src", output_source_selector, 0);
    check("rst_alu", alu_opcode, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // ALU(1), MOV, NOP with zero-wait memory
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c <= 9 && output_enable) cnt++;
      if (c == 1) begin
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 0);
      end
      if (c == 2) check("c2_req", imem_req, 0);
      if (c == 3) begin
        check("c3_oe", output_enable, 1);
        check("c3_alu", alu_opcode, 0);
        check("c3_src", output_source_selector, 0);
      end
      if (c == 6) begin
        check("c6_oe", output_enable, 1);
        check("c6_src", output_source_selector, 1);
      end
      if (c == 10) begin
        check("c10_pc", pc, 3);
        check("c10_retired", retired, 3);
      end
    end
    check("oe_pulses", cnt, 2);

    // Ack delayed by 4 cycles
    fill_halt();
    mem[0] = 32'h0000_0000;
    ack_delay = 4;
    do_reset();
    cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (imem_req) cnt++;
      if (c == 6) check("dly_instr", instruction_data, 32'h0000_0000);
      if (c == 7) check("dly_fault", fault, 0);
    end
    check("dly_req_cycles", cnt, 5);

    // Ack on the final allowed cycle beats the timeout
    fill_halt();
    mem[0] = 32'h0000_1234;
    ack_delay = 14;
    do_reset();
    repeat (16) @(negedge clock);
    check("last_ack_fault", fault, 0);
    check("last_ack_instr", instruction_data, 32'h0000_1234);

    // No ack at all -> timeout fault
    ack_en = 1'b0;
    ack_delay = 0;
    do_reset();
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (imem_req) cnt++;
      if (c == 15) check("to_c15_fault", fault, 0);
      if (c == 16) begin
        check("to_c16_fault", fault, 1);
        check("to_c16_req", imem_req, 0);
      end
    end
    check("to_req_cycles", cnt, 15);
    check("to_retired", retired, 0);
    ack_en = 1'b1;

    // JMP 0x10 then JMP 0x40
    fill_halt();
    mem[8'h00] = 32'h6000_0010;
    mem[8'h10] = 32'h6000_0040;
    do_reset();
    repeat (4) @(negedge clock);
    check("jmp1_addr", imem_addr, 8'h10);
    repeat (3) @(negedge clock);
    check("jmp2_addr", imem_addr, 8'h40);
    check("jmp2_retired", retired, 2);

    // PC wrap from 0xFF
    fill_halt();
    mem[8'h00] = 32'h6000_00FF;
    mem[8'hFF] = 32'h0000_0000;
    do_reset();
    repeat (4) @(negedge clock);
    check("wrap_ff_addr", imem_addr, 8'hFF);
    repeat (3) @(negedge clock);
    check("wrap_00_addr", imem_addr, 8'h00);
    check("wrap_pc", pc, 8'h00);

    // NOP then illegal 0x9
    fill_halt();
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h9000_0000;
    do_reset();
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (output_enable) cnt++;
      if (c >= 7 && imem_req) cnt = cnt + 100;
    end
    check("ill_oe_and_req", cnt, 0);
    check("ill_fault", fault, 1);
    check("ill_retired", retired, 1);
    check("ill_pc", pc, 1);
    check("ill_halted", halted, 0);

    // ALU(4) then HALT
    fill_halt();
    mem[0] = 32'h4000_0000;
    do_reset();
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 3) check("alu4_opcode", alu_opcode, 3);
      if (c >= 7 && imem_req) cnt++;
    end
    check("halt_req_after", cnt, 0);
    check("halt_halted", halted, 1);
    check("halt_retired", retired, 2);
    check("halt_pc", pc, 1);
    check("halt_fault", fault, 0);

    // Reset during EXECUTE of an ALU op
    fill_halt();
    mem[0] = 32'h2000_0000;
    do_reset();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rx_oe", output_enable, 0);
    check("rx_alu", alu_opcode, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rx_req", imem_req, 1);
    check("rx_addr", imem_addr, 0);
    check("rx_retired", retired, 0);
    repeat (2) @(negedge clock);
    check("rx_rerun_oe", output_enable, 1);
    check("rx_rerun_alu", alu_opcode, 1);
    @(negedge clock);
    check("rx_rerun_retired", retired, 1);

    // Reset during FETCH with ack asserted
    fill_halt();
    mem[0] = 32'h1234_5678;
    do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rf_instr", instruction_data, 0);
    check("rf_req", imem_req, 1);
    #1 reset = 1'b0;

    // Reset while halted
    fill_halt();
    do_reset();
    repeat (5) @(negedge clock);
    check("rh_pre_halted", halted, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rh_halted", halted, 0);
    check("rh_retired", retired, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rh_req", imem_req, 1);
    check("rh_addr", imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
